// File: rtl/bus_trace_monitor.sv
// Passive monitor for the memory request bus: tracks read/write handshakes, flags protocol
// errors and logs completed transactions into a FWFT trace FIFO. Optional: BUS_MON_ADDR_FILTER_EN.
module bus_trace_monitor #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned CNT_WIDTH   = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
  localparam int unsigned LVL_W      = $clog2(TRACE_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  mon_req_valid,
  input  logic                  mon_we,
  input  logic [ADDR_WIDTH-1:0] mon_addr,
  input  logic [DATA_WIDTH-1:0] mon_wdata,
  input  logic [DATA_WIDTH-1:0] mon_rdata,
  input  logic                  mon_valid_data,
`ifdef BUS_MON_ADDR_FILTER_EN
  input  logic [ADDR_WIDTH-1:0] filter_base,
  input  logic [ADDR_WIDTH-1:0] filter_mask,
`endif
  input  logic                  trace_pop,
  output logic                  trace_valid,
  output logic                  trace_we,
  output logic [ADDR_WIDTH-1:0] trace_addr,
  output logic [DATA_WIDTH-1:0] trace_data,
  output logic [LVL_W-1:0]      trace_level,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  overflow,
  output logic                  timeout_err,
  output logic                  overlap_err,
  output logic                  spurious_err
);

  localparam int unsigned PTR_W   = $clog2(TRACE_DEPTH);
  localparam int unsigned TMR_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [TMR_W-1:0] TimerMax = TMR_W'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [CNT_WIDTH-1:0]  wr_count_q, rd_count_q;
  logic                  overflow_q, timeout_q, overlap_q, spurious_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [ENTRY_W-1:0]    mem [TRACE_DEPTH];

  logic accept_req, rd_done, wr_done;
  logic set_spur, set_ovl, set_to;
  logic match_rd, match_wr;
  logic push_rd, push_wr, pop_eff, acc_rd, acc_wr, drop;
  logic [LVL_W-1:0] free;
  logic [PTR_W-1:0] wr_slot;

  // Handshake tracking; a request accepted alongside a read completion is handled as in idle
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    raddr_d    = raddr_q;
    accept_req = 1'b0;
    rd_done    = 1'b0;
    wr_done    = 1'b0;
    set_spur   = 1'b0;
    set_ovl    = 1'b0;
    set_to     = 1'b0;
    case (state_q)
      StIdle: begin
        set_spur   = mon_valid_data;
        accept_req = mon_req_valid;
      end
      StRdWait: begin
        if (mon_valid_data) begin
          rd_done    = 1'b1;
          state_d    = StIdle;
          timer_d    = '0;
          accept_req = mon_req_valid;
        end else if (mon_req_valid) begin
          set_ovl = 1'b1;
        end else if (timer_q == TimerMax) begin
          set_to  = 1'b1;
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (accept_req) begin
      if (mon_we) begin
        wr_done = 1'b1;
      end else begin
        raddr_d = mon_addr;
        timer_d = TMR_W'(1);
        state_d = StRdWait;
      end
    end
  end

`ifdef BUS_MON_ADDR_FILTER_EN
  assign match_rd = ((raddr_q & filter_mask) == (filter_base & filter_mask));
  assign match_wr = ((mon_addr & filter_mask) == (filter_base & filter_mask));
`else
  assign match_rd = 1'b1;
  assign match_wr = 1'b1;
`endif

  // Up to two pushes per cycle (read completion first, then write); a pop frees space first
  always_comb begin
    push_rd = rd_done & match_rd;
    push_wr = wr_done & match_wr;
    pop_eff = trace_pop & (level_q != '0);
    free    = LVL_W'(TRACE_DEPTH) - level_q + LVL_W'(pop_eff);
    acc_rd  = push_rd & (free != '0);
    acc_wr  = push_wr & (free > LVL_W'(acc_rd));
    drop    = (push_rd & ~acc_rd) | (push_wr & ~acc_wr);
    level_d = level_q + LVL_W'(acc_rd) + LVL_W'(acc_wr) - LVL_W'(pop_eff);
    wr_slot = wr_ptr_q + PTR_W'(acc_rd);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      raddr_q    <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      overlap_q  <= 1'b0;
      spurious_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else if (clear) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      raddr_q    <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      overlap_q  <= 1'b0;
      spurious_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      raddr_q    <= raddr_d;
      if (wr_done && wr_count_q != '1) wr_count_q <= wr_count_q + CNT_WIDTH'(1);
      if (rd_done && rd_count_q != '1) rd_count_q <= rd_count_q + CNT_WIDTH'(1);
      overflow_q <= overflow_q | drop;
      timeout_q  <= timeout_q | set_to;
      overlap_q  <= overlap_q | set_ovl;
      spurious_q <= spurious_q | set_spur;
      wr_ptr_q   <= wr_ptr_q + PTR_W'(acc_rd) + PTR_W'(acc_wr);
      rd_ptr_q   <= rd_ptr_q + PTR_W'(pop_eff);
      level_q    <= level_d;
    end
  end

  // Storage needs no reset: the outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (acc_rd) mem[wr_ptr_q] <= {1'b0, raddr_q, mon_rdata};
    if (acc_wr) mem[wr_slot]  <= {1'b1, mon_addr, mon_wdata};
  end

  logic [ENTRY_W-1:0] head;
  assign head         = mem[rd_ptr_q];
  assign trace_valid  = (level_q != '0);
  assign trace_we     = trace_valid & head[ENTRY_W-1];
  assign trace_addr   = head[DATA_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{trace_valid}};
  assign trace_data   = head[DATA_WIDTH-1:0] & {DATA_WIDTH{trace_valid}};
  assign trace_level  = level_q;
  assign wr_count     = wr_count_q;
  assign rd_count     = rd_count_q;
  assign overflow     = overflow_q;
  assign timeout_err  = timeout_q;
  assign overlap_err  = overlap_q;
  assign spurious_err = spurious_q;

endmodule

// File: doc/bus_trace_monitor.md
Name: bus_trace_monitor

Overview:
- Synthesizable, parametrised passive monitor for the SoC memory request bus (req_valid / we / addr / data / valid_data).
- Tracks read/write handshakes and counts completed transactions.
- Detects protocol errors: timeout, overlap and spurious response.
- Logs completed transactions into a trace FIFO that on-chip debug logic or a bench can drain.

Parameters:
- DATA_WIDTH, 32, bus data width.
- MEM_DEPTH, 64, memory words; ADDR_WIDTH = $clog2(MEM_DEPTH).
- TRACE_DEPTH, 8, trace FIFO entries; power of two, >= 2.
- TIMEOUT, 16, maximum cycles from read request to valid_data; >= 1.
- CNT_WIDTH, 16, width of the transaction counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of FIFO, counters, sticky flags and FSM.
- mon_req_valid  in  1  request strobe on the monitored bus.
- mon_we  in  1  1 = write, 0 = read; qualified by mon_req_valid.
- mon_addr  in  ADDR_WIDTH  request address.
- mon_wdata  in  DATA_WIDTH  write data; qualified by mon_req_valid & mon_we.
- mon_rdata  in  DATA_WIDTH  read data; qualified by mon_valid_data.
- mon_valid_data  in  1  read response strobe.
- trace_pop  in  1  pops the FIFO head.
- trace_valid  out  1  FIFO not empty.
- trace_we  out  1  head entry type.
- trace_addr  out  ADDR_WIDTH  head entry address.
- trace_data  out  DATA_WIDTH  head entry data.
- trace_level  out  $clog2(TRACE_DEPTH)+1  number of entries held.
- wr_count  out  CNT_WIDTH  completed writes.
- rd_count  out  CNT_WIDTH  completed reads.
- overflow  out  1  sticky: entry dropped because FIFO full.
- timeout_err  out  1  sticky: read response missing.
- overlap_err  out  1  sticky: request issued while a read is outstanding.
- spurious_err  out  1  sticky: valid_data with no outstanding read.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FIFO empty, FSM in IDLE, timer 0. The same state results from clear=1 on a clock edge. clear has priority over all other events in that cycle.
- FSM states: IDLE, RD_WAIT.
- IDLE:
  - req_valid & we: write completes this cycle and pushes entry {1, addr, wdata}; wr_count++.
  - req_valid & !we: capture addr, timer=1, go to RD_WAIT.
  - valid_data: sets spurious_err, even if a read request is present in the same cycle (minimum read latency is 1).
- RD_WAIT:
  - valid_data: push entry {0, captured addr, rdata}; rd_count++.
    - If req_valid is asserted in the same cycle, it is accepted as a new request (back-to-back, no error), processed as in IDLE.
    - Otherwise return to IDLE.
  - req_valid without valid_data: set overlap_err, ignore the request, stay in RD_WAIT.
  - Neither strobe and timer == TIMEOUT: set timeout_err, return to IDLE, no entry logged.
  - Neither strobe and timer < TIMEOUT: timer++.
  - Acceptance window: valid_data is accepted on cycles 1..TIMEOUT after the request cycle.
- Counters saturate at all-ones and do not wrap.
- Trace FIFO is first-word-fall-through:
  - trace_* show the head combinationally from storage.
  - A pushed entry is visible on trace_valid the cycle after the completing edge.
  - trace_level updates on the same edge.
- trace_pop when empty: ignored.
- Push when full without a pop: entry dropped, overflow set, counters still increment.
- Push and pop in the same cycle when full: both performed, level unchanged, no overflow.
- Push and pop in the same cycle when empty: only the push takes effect (the pop sees empty).
- Read/write pointers wrap modulo TRACE_DEPTH.
- Sticky flags are cleared only by reset or clear.
- Reset asserted mid-read: outstanding read discarded. A later valid_data with no new read request sets spurious_err.

Optional Feature:
- Macro BUS_MON_ADDR_FILTER_EN.
- Defined:
  - Adds inputs filter_base and filter_mask, each ADDR_WIDTH.
  - A completed transaction is pushed only if (addr & filter_mask) == (filter_base & filter_mask).
  - Counters, error flags and FSM are unaffected by the filter.
  - Filtered-out transactions never set overflow.
- Undefined: ports absent; every completed transaction is pushed.

Test Plan:
- Reset, then write addr 0x05 data 0xDEADBEEF → next cycle: trace_valid=1, trace_we=1, trace_addr=0x05, trace_data=0xDEADBEEF, wr_count=1, trace_level=1; pop → trace_valid=0.
- Read addr 0x10, valid_data 3 cycles later with rdata 0x12345678 → entry {0, 0x10, 0x12345678}, rd_count=1, no errors. Issue a second request in the same cycle as valid_data → accepted, overlap_err stays 0.
- Read with no response (TIMEOUT=16) → timeout_err=1 exactly 16 cycles after the request, FSM back in IDLE. Repeat with valid_data on cycle 16 → accepted, no error.
- 9 writes with TRACE_DEPTH=8 and no pops → trace_level=8, overflow=1, wr_count=9; pop all → data in order of writes 1..8. Push+pop while full → level stays 8.
- Read outstanding, extra req_valid → overlap_err=1; assert reset mid-read, then valid_data → spurious_err=1, rd_count=0.
- With BUS_MON_ADDR_FILTER_EN, base=0x20, mask=0x30: writes to 0x21 and 0x05 → only 0x21 logged, wr_count=2.
